// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with same-cycle write bypass
// and a per-register busy scoreboard for multi-cycle producers.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic                     wr_kill,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              we;
  logic              set_ok;

  // Gating with reset keeps the bypass from leaking a write while reset is held.
  assign we     = reset & wr_en & ~wr_kill & ~(ZR && (wr_addr == '0));
  assign set_ok = reset & busy_set & ~(ZR && (busy_addr == '0));

  // Clear first, then set, so a new producer wins over a retiring one.
  always_comb begin
    busy_next = busy;
    if (we)     busy_next[wr_addr]   = 1'b0;
    if (set_ok) busy_next[busy_addr] = 1'b1;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (we) mem[wr_addr] <= wr_data;
      busy <= busy_next;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit  = we && (wr_addr == addr);

    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = mem[addr];
      if (ZR && (addr == '0))
        rd_data[k*DATA_W +: DATA_W] = '0;
      else if (hit)
        rd_data[k*DATA_W +: DATA_W] = wr_data;
    end

    assign rd_busy[k] = busy[addr] & ~(hit & ~(busy_set & (busy_addr == wr_addr)));
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed literal checks plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_regfile_mp;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0, wr_kill = 1'b0, busy_set = 1'b0;
  logic [4:0]  wr_addr = '0, busy_addr = '0;
  logic [31:0] wr_data = '0;

  logic        b_reset = 1'b0;
  logic [11:0] b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_wr_en = 1'b0, b_wr_kill = 1'b0, b_busy_set = 1'b0;
  logic [2:0]  b_wr_addr = '0, b_busy_addr = '0;
  logic [15:0] b_wr_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  regfile_mp dut_a (
    .Clk(Clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_kill(wr_kill), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .Clk(Clk), .reset(b_reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_kill(b_wr_kill), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .busy_set(b_busy_set), .busy_addr(b_busy_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the default instance: plain arrays of register
  // contents and outstanding-producer flags.
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  function automatic bit m_we();
    return reset && wr_en && !wr_kill && wr_addr != 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (!reset || a == 0) return 32'h0;
    if (m_we() && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic m_bz(input logic [4:0] a);
    if (!reset || a == 0) return 1'b0;
    if (m_we() && wr_addr == a && !(busy_set && busy_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  always @(negedge reset)
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end

  always @(posedge Clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    end else begin
      if (m_we()) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 0;
      end
      if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1;
    end
  end

  always @(negedge Clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_rd%0d", k), rd_data[k*32 +: 32], m_rd(rd_addr[k*5 +: 5]));
      chk($sformatf("model_busy%0d", k), {31'b0, rd_busy[k]}, {31'b0, m_bz(rd_addr[k*5 +: 5])});
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic look();
    @(negedge Clk); #2;
  endtask

  initial begin
    // Writes presented during reset must not land.
    wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd3};
    look(); chk("reset_rd", rd_data[31:0], 32'h0);
    step(); step();
    reset = 1; b_reset = 1; wr_en = 0;
    look(); chk("post_reset_rd3", rd_data[31:0], 32'h0);
    chk("post_reset_busy", {31'b0, rd_busy[0]}, 32'h0);

    step(); wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; rd_addr = {5'd8, 5'd7};
    look(); chk("bypass_rd7", rd_data[31:0], 32'h12345678);
    chk("rd8_zero", rd_data[63:32], 32'h0);
    step(); wr_en = 0;
    look(); chk("stored_rd7", rd_data[31:0], 32'h12345678);

    step(); wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rd_addr = {5'd7, 5'd0};
    look(); chk("zero_reg_bypass", rd_data[31:0], 32'h0);
    step(); wr_en = 0;
    look(); chk("zero_reg_stored", rd_data[31:0], 32'h0);

    step(); wr_en = 1; wr_kill = 1; wr_addr = 9; wr_data = 32'hAAAA5555; rd_addr = {5'd0, 5'd9};
    look(); chk("kill_no_bypass", rd_data[31:0], 32'h0);
    step(); wr_en = 0; wr_kill = 0;
    look(); chk("kill_no_store", rd_data[31:0], 32'h0);

    step(); busy_set = 1; busy_addr = 5; rd_addr = {5'd0, 5'd5};
    look(); chk("busy_not_yet", {31'b0, rd_busy[0]}, 32'h0);
    step(); busy_set = 0;
    look(); chk("busy_set5", {31'b0, rd_busy[0]}, 32'h1);
    step(); wr_en = 1; wr_addr = 5; wr_data = 32'h55;
    look(); chk("retire_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("retire_data", rd_data[31:0], 32'h55);
    step(); wr_en = 0;
    look(); chk("busy_stays_clear", {31'b0, rd_busy[0]}, 32'h0);

    step(); busy_set = 1; busy_addr = 6; rd_addr = {5'd6, 5'd6};
    step(); wr_en = 1; wr_addr = 6; wr_data = 32'h66;
    look(); chk("collide_same_cycle_busy", {31'b0, rd_busy[0]}, 32'h1);
    step(); wr_en = 0; busy_set = 0;
    look(); chk("collide_data", rd_data[31:0], 32'h66);
    chk("collide_busy0", {31'b0, rd_busy[0]}, 32'h1);
    chk("collide_busy1", {31'b0, rd_busy[1]}, 32'h1);
    chk("collide_data1", rd_data[63:32], 32'h66);

    step(); busy_set = 1; busy_addr = 0; rd_addr = {5'd0, 5'd0};
    step(); busy_set = 0;
    look(); chk("zero_never_busy", {31'b0, rd_busy[0]}, 32'h0);

    // Reduced-width instance without a hardwired zero register.
    step(); b_wr_en = 1; b_wr_addr = 0; b_wr_data = 16'hBEEF; b_rd_addr = '0;
    look();
    for (int k = 0; k < 4; k++) chk($sformatf("b_bypass%0d", k), {16'h0, b_rd_data[k*16 +: 16]}, 32'hBEEF);
    step(); b_wr_addr = 5; b_wr_data = 16'h1234; b_busy_set = 1; b_busy_addr = 2;
    step(); b_wr_en = 0; b_busy_set = 0; b_rd_addr = {3'd2, 3'd5, 3'd0, 3'd0};
    look();
    for (int k = 0; k < 4; k++) chk($sformatf("b_stored%0d", k), {16'h0, b_rd_data[k*16 +: 16]}, (k >= 2 ? (k == 3 ? 32'h0 : 32'h1234) : 32'hBEEF));
    chk("b_busy2", {28'h0, b_rd_busy}, 32'h8);
    #1 b_reset = 0; #1;
    for (int k = 0; k < 4; k++) chk($sformatf("b_async_rst%0d", k), {16'h0, b_rd_data[k*16 +: 16]}, 32'h0);
    chk("b_async_rst_busy", {28'h0, b_rd_busy}, 32'h0);
    step(); b_reset = 1;
    look(); chk("b_after_rst", {16'h0, b_rd_data[15:0]}, 32'h0);

    // Randomized traffic concentrated on few registers to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      step();
      wr_en     = ($urandom_range(0, 99) < 55);
      wr_kill   = ($urandom_range(0, 99) < 10);
      wr_addr   = 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      busy_set  = ($urandom_range(0, 99) < 35);
      busy_addr = 5'($urandom_range(0, 7));
      rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if (n % 97 == 13) rd_addr = 10'($urandom);
      if (n == 300) begin
        #2 reset = 0;
        step();
        reset = 1;
      end
    end
    step(); wr_en = 0; busy_set = 0;
    look();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
